// File: rtl/pico_qsys_onchip_mem_pkg.sv
// Shared definitions for the pico_qsys on-chip memory slave.
//   state_t         read FSM encoding (IDLE / BURST)
//   LAT_MIN/LAT_MAX supported read latencies
//   clog2()         width helper usable in parameter port lists
package pico_qsys_onchip_mem_pkg;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_BURST = 1'b1
    } state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    // Never returns 0 so a degenerate DEPTH/MAX_BURST of 1 still yields a legal width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pico_qsys_onchip_mem_array.sv
// Inferred single-port synchronous RAM with byte-lane writes.
//   clk, clken     clock and global stall (no access while clken=0)
//   we, be, wdata  write strobe, lane enables, write data (written at addr)
//   re, addr       read strobe and address; the address is registered
//   rdata          word at the registered read address
module pico_qsys_onchip_mem_array
    import pico_qsys_onchip_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 4096,
    parameter int    ADDR_W    = 12,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                clken,
    input  logic                we,
    input  logic                re,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_r;

    always_ff @(posedge clk) begin
        if (clken) begin
            if (we) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            if (re) addr_r <= addr;
        end
    end

    // Holding addr_r while stalled keeps rdata stable, so a held beat stays intact.
    assign rdata = mem[addr_r];

endmodule

// File: rtl/pico_qsys_onchip_mem.sv
// Avalon-MM on-chip memory slave (ROM or RAM) with pipelined, wrapping read bursts.
//   clk, reset_n                 clock, async active-low reset
//   address/chipselect/read/write/byteenable/writedata/burstcount  Avalon command
//   debugaccess                  allows writes in ROM mode
//   clken                        global stall, freezes FSM, pipe and array
//   reset_req                    blocks new commands; an active burst still drains
//   waitrequest/readdata/readdatavalid  Avalon response
//   wr_blocked                   one-cycle pulse when ROM protection rejects a write
//
// state | meaning
// IDLE  | accepting commands; a read issues its first beat here
// BURST | issuing remaining beats of a read burst, waitrequest held high
module pico_qsys_onchip_mem
    import pico_qsys_onchip_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 4096,
    parameter int    READ_LATENCY = 1,
    parameter int    WRITABLE     = 0,
    parameter int    MAX_BURST    = 8,
    parameter string INIT_FILE    = "fw.hex",
    localparam int   ADDR_W       = clog2(DEPTH),
    localparam int   BURST_W      = clog2(MAX_BURST) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [BURST_W-1:0]  burstcount,
    input  logic                debugaccess,
    input  logic                clken,
    input  logic                reset_req,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                wr_blocked
);

    localparam logic [BURST_W-1:0] MAX_BEATS = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] ONE_BEAT  = BURST_W'(1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt, issue_addr;
    logic [BURST_W-1:0]  cnt_q, cnt_nxt, beats;
    logic                in_reset, issue, rvalid1;
    logic                cmd_ok, rd_cmd, wr_cmd, wr_allowed;
    logic [DATA_W-1:0]   arr_rdata;

    assign waitrequest = (state == STATE_BURST) | reset_req | in_reset;
    assign cmd_ok      = chipselect & ~waitrequest & clken;
    assign wr_cmd      = cmd_ok & write;
    assign rd_cmd      = cmd_ok & read & ~write;   // read+write counts as a write only
    assign wr_allowed  = (WRITABLE != 0) | debugaccess;

    always_comb begin
        beats = burstcount;
        if (burstcount == '0)            beats = ONE_BEAT;
        else if (burstcount > MAX_BEATS) beats = MAX_BEATS;
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        cnt_nxt    = cnt_q;
        issue      = 1'b0;
        issue_addr = address;
        case (state)
            STATE_IDLE: begin
                if (rd_cmd) begin
                    issue    = 1'b1;
                    addr_nxt = address + ADDR_W'(1);
                    cnt_nxt  = beats - ONE_BEAT;
                    if (beats != ONE_BEAT) state_nxt = STATE_BURST;
                end
            end
            STATE_BURST: begin
                issue_addr = addr_q;
                if (clken) begin
                    issue    = 1'b1;
                    addr_nxt = addr_q + ADDR_W'(1);   // wraps at DEPTH-1
                    cnt_nxt  = cnt_q - ONE_BEAT;
                    if (cnt_q == ONE_BEAT) state_nxt = STATE_IDLE;
                end
            end
            default: state_nxt = STATE_IDLE;
        endcase
    end

    // Keeps waitrequest high for exactly one edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) in_reset <= 1'b1;
        else          in_reset <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= STATE_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            rvalid1 <= 1'b0;
        end else if (clken) begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            cnt_q   <= cnt_nxt;
            rvalid1 <= issue;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wr_blocked <= 1'b0;
        else          wr_blocked <= wr_cmd & ~wr_allowed;
    end

    pico_qsys_onchip_mem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .clken (clken),
        .we    (wr_cmd & wr_allowed),
        .re    (issue),
        .be    (byteenable),
        .addr  (issue_addr),
        .wdata (writedata),
        .rdata (arr_rdata)
    );

    generate
        if (READ_LATENCY == LAT_MAX) begin : g_lat2
            logic [DATA_W-1:0] rdata_q;
            logic              rvalid2;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rdata_q <= '0;
                    rvalid2 <= 1'b0;
                end else if (clken) begin
                    rvalid2 <= rvalid1;
                    if (rvalid1) rdata_q <= arr_rdata;
                end
            end
            assign readdata      = rdata_q;
            assign readdatavalid = rvalid2;
        end else begin : g_lat1
            // Masking gives readdata=0 in reset without a reset on the RAM output.
            assign readdata      = rvalid1 ? arr_rdata : '0;
            assign readdatavalid = rvalid1;
        end
    endgenerate

endmodule

// File: tb/tb_pico_qsys_onchip_mem.sv
module tb_pico_qsys_onchip_mem;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] address = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [3:0]  byteenable = 4'hF;
    logic [31:0] writedata = '0;
    logic [3:0]  burstcount = 4'd1;
    logic        debugaccess = 1'b0, clken = 1'b1, reset_req = 1'b0;

    logic        wait1, rdv1, wb1, wait2, rdv2, wb2;
    logic [31:0] rd1, rd2;

    logic [31:0] model [4096];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pico_qsys_onchip_mem #(.READ_LATENCY(1), .WRITABLE(0), .INIT_FILE("")) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
        .burstcount(burstcount), .debugaccess(debugaccess), .clken(clken),
        .reset_req(reset_req), .waitrequest(wait1), .readdata(rd1),
        .readdatavalid(rdv1), .wr_blocked(wb1));

    pico_qsys_onchip_mem #(.READ_LATENCY(2), .WRITABLE(0), .INIT_FILE("")) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
        .burstcount(burstcount), .debugaccess(debugaccess), .clken(clken),
        .reset_req(reset_req), .waitrequest(wait2), .readdata(rd2),
        .readdatavalid(rdv2), .wr_blocked(wb2));

    function automatic logic [31:0] pat(input logic [11:0] a);
        return {4'hA, a, 4'h5, a};
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Issue one read burst at the current negedge and watch both latencies for 24 cycles.
    // n1e/n2e: beats expected from the LAT=1/LAT=2 instance; wait_e < 0 skips the waitrequest count.
    task automatic do_read(input logic [11:0] a, input logic [3:0] bc, input int n1e, input int n2e,
                           input int stall_k, input int rst_k, input int wait_e, input string tag);
        int n1 = 0, n2 = 0, nw = 0;
        logic p_rdv1, p_rdv2;
        logic [31:0] p_rd1, p_rd2;
        logic [11:0] ix;
        chk_val({tag, "_wpre1"}, 32'(wait1), 32'd0);
        chk_val({tag, "_wpre2"}, 32'(wait2), 32'd0);
        chipselect = 1'b1; read = 1'b1; address = a; burstcount = bc;
        p_rdv1 = rdv1; p_rdv2 = rdv2; p_rd1 = rd1; p_rd2 = rd2;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (wait1) nw++;
            if (clken) begin
                if (rdv1) begin
                    if (n1 < n1e) begin
                        ix = a + 12'(n1);
                        chk_val({tag, "_d1"}, rd1, model[ix]);
                        if (stall_k < 0) chk_val({tag, "_t1"}, 32'(k), 32'(n1 + 1));
                    end
                    n1++;
                end
                if (rdv2) begin
                    if (n2 < n2e) begin
                        ix = a + 12'(n2);
                        chk_val({tag, "_d2"}, rd2, model[ix]);
                        if (stall_k < 0) chk_val({tag, "_t2"}, 32'(k), 32'(n2 + 2));
                    end
                    n2++;
                end
            end else begin
                chk_val({tag, "_hold_v1"}, 32'(rdv1), 32'(p_rdv1));
                chk_val({tag, "_hold_d1"}, rd1, p_rd1);
                chk_val({tag, "_hold_v2"}, 32'(rdv2), 32'(p_rdv2));
                chk_val({tag, "_hold_d2"}, rd2, p_rd2);
            end
            p_rdv1 = rdv1; p_rdv2 = rdv2; p_rd1 = rd1; p_rd2 = rd2;
            if (k == 1) begin chipselect = 1'b0; read = 1'b0; burstcount = 4'd1; end
            if (stall_k > 0 && k == stall_k)     clken = 1'b0;
            if (stall_k > 0 && k == stall_k + 3) clken = 1'b1;
            if (rst_k > 0 && k == rst_k)         reset_n = 1'b0;
            if (rst_k > 0 && k == rst_k + 2)     reset_n = 1'b1;
        end
        chk_val({tag, "_beats1"}, 32'(n1), 32'(n1e));
        chk_val({tag, "_beats2"}, 32'(n2), 32'(n2e));
        if (wait_e >= 0) chk_val({tag, "_waitcyc"}, 32'(nw), 32'(wait_e));
    endtask

    task automatic wr_word(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, input string tag);
        chk_val({tag, "_wpre"}, 32'(wait1), 32'd0);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        byteenable = be; debugaccess = dbg;
        @(negedge clk);
        chk_val({tag, "_blk1"}, 32'(wb1), 32'(!dbg));
        chk_val({tag, "_blk2"}, 32'(wb2), 32'(!dbg));
        chipselect = 1'b0; write = 1'b0; debugaccess = 1'b0; byteenable = 4'hF;
        if (dbg) begin
            for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        end
        @(negedge clk);
        chk_val({tag, "_blkend"}, 32'(wb1), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model[i] = pat(12'(i));

        // reset state
        repeat (2) @(negedge clk);
        chk_val("rst_wait1", 32'(wait1), 32'd1);
        chk_val("rst_wait2", 32'(wait2), 32'd1);
        chk_val("rst_rdv1", 32'(rdv1), 32'd0);
        chk_val("rst_rdv2", 32'(rdv2), 32'd0);
        chk_val("rst_rd1", rd1, 32'd0);
        chk_val("rst_rd2", rd2, 32'd0);
        chk_val("rst_wb1", 32'(wb1), 32'd0);
        reset_n = 1'b1;
        #1 chk_val("rel_wait_before_edge", 32'(wait1), 32'd1);
        @(negedge clk);
        chk_val("rel_wait1", 32'(wait1), 32'd0);
        chk_val("rel_wait2", 32'(wait2), 32'd0);
        chk_val("rel_rdv1", 32'(rdv1), 32'd0);

        // preload the ROM image through the debug write path
        chipselect = 1'b1; write = 1'b1; debugaccess = 1'b1; byteenable = 4'hF;
        for (int i = 0; i < 4096; i++) begin
            address = 12'(i);
            writedata = pat(12'(i));
            @(negedge clk);
        end
        chipselect = 1'b0; write = 1'b0; debugaccess = 1'b0;
        @(negedge clk);

        do_read(12'h010, 4'd1, 1, 1, -1, -1, 0, "rd010");
        chk_val("rd010_word", model[12'h010], 32'hA0105010);
        do_read(12'hFFE, 4'd4, 4, 4, -1, -1, 3, "wrap");

        wr_word(12'h020, 32'hDEADBEEF, 4'b1111, 1'b0, "rom_wr");
        do_read(12'h020, 4'd1, 1, 1, -1, -1, 0, "rom_rb");
        wr_word(12'h020, 32'hDEADBEEF, 4'b0011, 1'b1, "dbg_wr");
        do_read(12'h020, 4'd1, 1, 1, -1, -1, 0, "dbg_rb");

        do_read(12'h040, 4'd4, 4, 4, 2, -1, -1, "stall");
        do_read(12'h100, 4'd0, 1, 1, -1, -1, 0, "bc0");
        do_read(12'h200, 4'd15, 8, 8, -1, -1, 7, "bc15");

        // soft-reset request blocks a new command
        reset_req = 1'b1; chipselect = 1'b1; read = 1'b1; address = 12'h005;
        #1 chk_val("rreq_wait1", 32'(wait1), 32'd1);
        chk_val("rreq_wait2", 32'(wait2), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_val("rreq_rdv1", 32'(rdv1), 32'd0);
            chk_val("rreq_rdv2", 32'(rdv2), 32'd0);
        end
        reset_req = 1'b0; chipselect = 1'b0; read = 1'b0;
        @(negedge clk);
        chk_val("rreq_rdv_after", 32'(rdv1), 32'd0);

        // reset during beat 2 of a burst of 8
        do_read(12'h300, 4'd8, 2, 1, -1, 2, -1, "rstmid");
        do_read(12'h005, 4'd1, 1, 1, -1, -1, 0, "rd005");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
